// File: rtl/add_and_or_unit.sv
// Registered ADD/AND/OR slice with an optional {N,Z,C,V} flag update and one-cycle latency.
// Define ADC_CARRY_EN to make op=11 an add-with-carry; otherwise op=11 is a reserved no-op.
module add_and_or_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic             sbit,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [3:0]       flags
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_ADC = 2'b11;

    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH:0]   sum_ext;
    logic             carry, ovf;
    logic             is_arith;
    logic             flag_upd;

    always_comb begin
`ifdef ADC_CARRY_EN
        // Carry-in is the registered C at the issue edge, so an ADC right after
        // a flag-setting ADD sees that ADD's carry.
        sum_ext = {1'b0, in1} + {1'b0, in2}
                  + {{WIDTH{1'b0}}, (op == OP_ADC) ? flags_q[1] : 1'b0};
`else
        sum_ext = {1'b0, in1} + {1'b0, in2};
`endif
        carry = sum_ext[WIDTH];
        ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_ext[WIDTH-1] != in1[WIDTH-1]);
    end

    always_comb begin
        result_d = result_q;
        valid_d  = in_valid;
        flags_d  = flags_q;
        is_arith = 1'b0;
        flag_upd = in_valid && sbit;

        if (in_valid) begin
            unique case (op)
                OP_ADD: begin
                    result_d = sum_ext[WIDTH-1:0];
                    is_arith = 1'b1;
                end
                OP_AND: result_d = in1 & in2;
                OP_OR:  result_d = in1 | in2;
                OP_ADC: begin
`ifdef ADC_CARRY_EN
                    result_d = sum_ext[WIDTH-1:0];
                    is_arith = 1'b1;
`else
                    result_d = '0;
                    flag_upd = 1'b0;
`endif
                end
                default: result_d = '0;
            endcase
        end

        if (flag_upd) begin
            flags_d[3] = result_d[WIDTH-1];
            flags_d[2] = (result_d == '0);
            if (is_arith) begin
                flags_d[1] = carry;
                flags_d[0] = ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            flags_q  <= 4'b0000;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
            flags_q  <= flags_d;
        end
    end

    assign result    = result_q;
    assign out_valid = valid_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_add_and_or_unit.sv
// Scoreboard bench for add_and_or_unit: driver pushes {result,flags} expectations, monitor pops on out_valid.
// Expectations for op=11 follow ADC_CARRY_EN.
module tb_add_and_or_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [1:0]   op;
    logic         sbit;
    logic [W-1:0] in1, in2;
    logic [W-1:0] result;
    logic         out_valid;
    logic [3:0]   flags;

    logic [W+3:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_issued = 0;
    int n_out = 0;

    add_and_or_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .sbit(sbit),
        .in1(in1), .in2(in2), .result(result), .out_valid(out_valid), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request on the next rising edge; in_valid stays high so calls chain back-to-back.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] er, input logic [3:0] ef);
        in_valid = 1'b1; op = o; in1 = a; in2 = b; sbit = s;
        exp_q.push_back({er, ef});
        n_issued++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; op = 2'b00; sbit = 1'b0; in1 = '0; in2 = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: compare every presented output against the head of the queue.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: got result 0x%08h flags %b, no request pending", result, flags);
            end else begin
                logic [W+3:0] e;
                e = exp_q.pop_front();
                check("result", result, e[W+3:4]);
                check("flags", {28'd0, flags}, {28'd0, e[3:0]});
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = 2'b00; sbit = 1'b0; in1 = '0; in2 = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_result", result, '0);
        check("reset_flags", {28'd0, flags}, '0);
        check("reset_valid", {31'd0, out_valid}, '0);
        idle(2);
        check("idle_result", result, '0);
        check("idle_valid", {31'd0, out_valid}, '0);

        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110);
        idle(1);
        issue(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1001);
        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110);
        issue(2'b01, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'h00F0_00F0, 4'b0010);
        issue(2'b10, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h8000_0001, 4'b0010);
        issue(2'b00, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0010);
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 4'b1010);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 4'b0111);
        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110);
`ifdef ADC_CARRY_EN
        issue(2'b11, 32'h0000_0002, 32'h0000_0003, 1'b1, 32'h0000_0006, 4'b0000);
        issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b1000);
`else
        issue(2'b11, 32'h0000_0002, 32'h0000_0003, 1'b1, 32'h0000_0000, 4'b0110);
        issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110);
`endif
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE,
`ifdef ADC_CARRY_EN
              4'b1000);
`else
              4'b0110);
`endif
        idle(2);
        check("hold_result", result, 32'hFFFF_FFFE);
        check("hold_valid", {31'd0, out_valid}, '0);

        // Reset wins over a simultaneous request.
        in_valid = 1'b1; op = 2'b00; in1 = 32'd1; in2 = 32'd1; sbit = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        check("rst_mid_result", result, '0);
        check("rst_mid_flags", {28'd0, flags}, '0);
        check("rst_mid_valid", {31'd0, out_valid}, '0);
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("one_out_per_req", n_out, n_issued);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
